audio_pwm_out: RTL and testbench

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pkg.sv | 17 +
 rtl/pwm_channel.sv | 38 +++
 rtl/audio_pwm_out.sv | 157 +++++++++++++++
 tb/tb_audio_pwm_out.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and the soft-mute state encoding for the audio PWM output block.
package audio_pkg;

    localparam int unsigned DefSampleW  = 16;
    localparam int unsigned DefPwmW     = 8;
    localparam int unsigned DefNumCh    = 2;
    localparam int unsigned DefGainW    = 6;
    localparam int unsigned DefGainFull = 1 << DefGainW;

    typedef enum logic [1:0] {
        StUnmuted,
        StRampDown,
        StMuted,
        StRampUp
    } mute_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output lane: level register reloaded at the period boundary plus comparator.
module pwm_channel #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [PWM_W-1:0] level_i,
    input  logic [PWM_W-1:0] cnt_i,
    output logic             pwm_o
);

    localparam logic [PWM_W-1:0] MidLevel = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0] level_q, level_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        level_d = level_q;
        if (load_i) begin
            level_d = level_i;
        end
        pwm_d = (cnt_i < level_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q <= MidLevel;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Multi-channel audio PWM output with volume scaling, sample double-buffering and
// a period-synchronous soft-mute gain ramp.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DefSampleW,
    parameter int unsigned PWM_W    = DefPwmW,
    parameter int unsigned NUM_CH   = DefNumCh,
    parameter int unsigned GAIN_W   = DefGainW
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  sample_in,
    input  logic                             valid_in,
    input  logic [2:0]                       vol_in,
    input  logic                             mute_in,
    output logic [NUM_CH-1:0]                pwm_out,
    output logic                             period_start_out,
    output logic                             muted_out,
    output logic                             overrun_out
);

    localparam int unsigned   ProdW    = SAMPLE_W + GAIN_W + 2;
    localparam logic [GAIN_W:0] GainFull = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] GainOne  = {{GAIN_W{1'b0}}, 1'b1};

    logic [PWM_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  pend_q, pend_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold_q, hold_d;
    logic                             pend_vld_q, pend_vld_d;
    logic                             overrun_q, overrun_d;
    logic [GAIN_W:0]                  gain_q, gain_d;
    mute_state_e                      state_q, state_d;
    logic                             period_end;

    assign period_end = (cnt_q == '1);

    // Sample path: pending buffer refilled by valid_in, promoted to hold at period end.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        hold_d     = hold_q;
        overrun_d  = valid_in && pend_vld_q && !period_end;
        if (valid_in) begin
            pend_d = sample_in;
        end
        if (period_end) begin
            if (pend_vld_q) begin
                hold_d = pend_q;
            end
            pend_vld_d = valid_in;
        end else if (valid_in) begin
            pend_vld_d = 1'b1;
        end
    end

    // Soft-mute ramp: one gain step per period end toward the mute_in target.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (period_end) begin
            unique case (state_q)
                StUnmuted: begin
                    if (mute_in) begin
                        gain_d  = gain_q - 1'b1;
                        state_d = (gain_q == GainOne) ? StMuted : StRampDown;
                    end
                end
                StRampDown: begin
                    if (mute_in) begin
                        gain_d  = gain_q - 1'b1;
                        state_d = (gain_q == GainOne) ? StMuted : StRampDown;
                    end else begin
                        gain_d  = gain_q + 1'b1;
                        state_d = (gain_d == GainFull) ? StUnmuted : StRampUp;
                    end
                end
                StMuted: begin
                    if (!mute_in) begin
                        gain_d  = gain_q + 1'b1;
                        state_d = (gain_d == GainFull) ? StUnmuted : StRampUp;
                    end
                end
                StRampUp: begin
                    if (mute_in) begin
                        gain_d  = gain_q - 1'b1;
                        state_d = (gain_q == GainOne) ? StMuted : StRampDown;
                    end else begin
                        gain_d  = gain_q + 1'b1;
                        state_d = (gain_d == GainFull) ? StUnmuted : StRampUp;
                    end
                end
                default: begin
                    state_d = StMuted;
                    gain_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            hold_q     <= '0;
            overrun_q  <= 1'b0;
            gain_q     <= '0;
            state_q    <= StMuted;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hold_q     <= hold_d;
            overrun_q  <= overrun_d;
            gain_q     <= gain_d;
            state_q    <= state_d;
        end
    end

    // hold_d is the sample selected for the coming period; gain_q is the pre-update gain.
    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        logic signed [SAMPLE_W-1:0] att;
        logic signed [ProdW-1:0]    att_ext;
        logic signed [ProdW-1:0]    gain_ext;
        logic signed [ProdW-1:0]    prod;
        logic signed [ProdW-1:0]    scaled;
        logic [PWM_W-1:0]           level;
        logic                       unused_scaled;

        assign att      = $signed(hold_d[c]) >>> (3'd7 - vol_in);
        assign att_ext  = {{(ProdW - SAMPLE_W){att[SAMPLE_W-1]}}, att};
        assign gain_ext = {{(ProdW - GAIN_W - 1){1'b0}}, gain_q};
        assign prod     = att_ext * gain_ext;
        assign scaled   = prod >>> GAIN_W;
        // Offset binary: flip the sign bit so zero maps to mid-scale.
        assign level    = {~scaled[SAMPLE_W-1], scaled[SAMPLE_W-2 -: PWM_W-1]};
        assign unused_scaled = ^scaled;

        pwm_channel #(
            .PWM_W(PWM_W)
        ) u_pwm_channel (
            .clk_i  (clk_in),
            .rst_ni (rst_n_in),
            .load_i (period_end),
            .level_i(level),
            .cnt_i  (cnt_q),
            .pwm_o  (pwm_out[c])
        );
    end

    assign period_start_out = !rst_n_in || (cnt_q == '0);
    assign muted_out        = !rst_n_in || (state_q == StMuted);
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Scoreboard bench: stimulus queues expected per-period duty cycles, a monitor measures
// each PWM period and compares; control/status checks are made inline.
module tb_audio_pwm_out;
    import audio_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0][15:0] sample;
    logic             valid;
    logic [2:0]       vol;
    logic             mute;
    logic [1:0]       pwm;
    logic             period_start;
    logic             muted;
    logic             overrun;

    audio_pwm_out dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .sample_in       (sample),
        .valid_in        (valid),
        .vol_in          (vol),
        .mute_in         (mute),
        .pwm_out         (pwm),
        .period_start_out(period_start),
        .muted_out       (muted),
        .overrun_out     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    at;
        int    d0;
        int    d1;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mon_period = 0;
    int   acc0 = 0;
    int   acc1 = 0;
    int   ovr_cnt = 0;
    bit   muted_seen = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: a window closes at the cycle period_start is seen, whose pwm bit reflects
    // the last count of the period just ended.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc0 = 0;
                acc1 = 0;
            end else begin
                acc0 += int'(pwm[0]);
                acc1 += int'(pwm[1]);
                if (overrun) ovr_cnt++;
                if (muted) muted_seen = 1'b1;
                if (period_start) begin
                    mon_period++;
                    while (exp_q.size() > 0 && exp_q[0].at <= mon_period) begin
                        e = exp_q.pop_front();
                        if (e.at == mon_period) begin
                            check({e.name, "_ch0"}, acc0, e.d0);
                            check({e.name, "_ch1"}, acc1, e.d1);
                        end else begin
                            check({e.name, "_missed"}, mon_period, e.at);
                        end
                    end
                    acc0 = 0;
                    acc1 = 0;
                end
            end
        end
    end

    task automatic next_period_start();
        int n;
        n = 0;
        @(negedge clk);
        while (period_start && n < 600) begin
            @(negedge clk);
            n++;
        end
        while (!period_start && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("period_timeout", n, 0);
    endtask

    task automatic wait_periods(input int n);
        repeat (n) next_period_start();
    endtask

    task automatic send(input logic [15:0] s0, input logic [15:0] s1);
        sample[0] = s0;
        sample[1] = s1;
        valid     = 1'b1;
        @(negedge clk);
        valid     = 1'b0;
    endtask

    task automatic push(input string name, input int d0, input int d1, input int ahead);
        exp_t e;
        e.at   = mon_period + ahead;
        e.d0   = d0;
        e.d1   = d1;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        int o0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        sample = '0;
        vol    = 3'd7;
        mute   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_period_start", int'(period_start), 1);
        check("rst_muted", int'(muted), 1);
        check("rst_gain", int'(dut.gain_q), 0);

        // Power-on ramp from silence
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_muted", int'(muted), 1);
        check("post_rst_period_start", int'(period_start), 0);
        next_period_start();
        check("ramp_start_muted", int'(muted), 0);
        check("ramp_start_state", int'(dut.state_q), int'(StRampUp));
        check("ramp_start_gain", int'(dut.gain_q), 1);
        wait_periods(63);
        check("ramp_done_gain", int'(dut.gain_q), 64);
        check("ramp_done_state", int'(dut.state_q), int'(StUnmuted));

        // Volume / level mapping
        @(negedge clk);
        push("vol7_half", 192, 64, 2);
        send(16'h4000, 16'hC000);
        next_period_start();
        @(negedge clk);
        vol = 3'd0;
        push("vol0_minmax", 127, 128, 2);
        send(16'h8000, 16'h0000);
        next_period_start();
        @(negedge clk);
        push("vol0_swap", 128, 127, 2);
        send(16'h0000, 16'h8000);
        next_period_start();
        @(negedge clk);
        vol = 3'd3;
        push("vol3", 132, 135, 2);
        send(16'h4000, 16'h7FFF);

        // Two samples in one period: one overrun, last one wins
        next_period_start();
        @(negedge clk);
        vol = 3'd7;
        o0  = ovr_cnt;
        push("overrun_last", 160, 128, 2);
        send(16'h1000, 16'h0000);
        repeat (3) @(negedge clk);
        send(16'h2000, 16'h0000);
        repeat (3) @(negedge clk);
        check("overrun_pulses", ovr_cnt - o0, 1);

        // Refill exactly at period end: no overrun, both samples play in order
        next_period_start();
        @(negedge clk);
        o0 = ovr_cnt;
        push("boundary_a", 144, 128, 2);
        push("boundary_b", 176, 128, 3);
        send(16'h1000, 16'h0000);
        repeat (253) @(negedge clk);
        send(16'h3000, 16'h0000);
        repeat (3) @(negedge clk);
        check("boundary_no_overrun", ovr_cnt - o0, 0);

        // Partial soft-mute and recovery
        next_period_start();
        @(negedge clk);
        send(16'h4000, 16'h0000);
        next_period_start();
        @(negedge clk);
        mute       = 1'b1;
        muted_seen = 1'b0;
        wait_periods(10);
        check("mute10_gain", int'(dut.gain_q), 54);
        check("mute10_state", int'(dut.state_q), int'(StRampDown));
        @(negedge clk);
        push("mute_gain55", 183, 128, 1);
        push("mute_gain54", 182, 128, 2);
        mute = 1'b0;
        wait_periods(10);
        check("unmute_gain", int'(dut.gain_q), 64);
        check("unmute_state", int'(dut.state_q), int'(StUnmuted));
        check("never_muted", int'(muted_seen), 0);

        // Reset in the middle of a ramp-down
        next_period_start();
        @(negedge clk);
        mute = 1'b1;
        wait_periods(3);
        check("ramp_down_gain", int'(dut.gain_q), 61);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pwm", int'(pwm), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_period_start", int'(period_start), 1);
        check("mid_rst_muted", int'(muted), 1);
        check("mid_rst_gain", int'(dut.gain_q), 0);
        check("mid_rst_state", int'(dut.state_q), int'(StMuted));
        repeat (2) @(negedge clk);
        mute  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_muted", int'(muted), 1);
        next_period_start();
        check("rerelease_state", int'(dut.state_q), int'(StRampUp));
        check("rerelease_gain", int'(dut.gain_q), 1);

        wait_periods(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
